// File: rtl/mcu_addr_seq_if.sv
// Connects the 8051-style address sequencer to code memory (hold, code_data)
// and to the datapath (timing, PC controls and one-hot bus selects).
interface mcu_addr_seq_if #(
    parameter int SFR_NUM = 7,
    parameter int CYC_W   = 2
);
    logic               hold;
    logic [7:0]         code_data;
    logic [2:0]         S;
    logic               Phase;
    logic [CYC_W-1:0]   cycles;
    logic [7:0]         IR_q;
    logic               PC_en;
    logic               PC_add_rel;
    logic               Jump_flag;
    logic               Rn_ext;
    logic               Ri_at;
    logic [SFR_NUM+5:0] Addr_src;
    logic [SFR_NUM+7:0] Addr_dst;
    logic               illegal_op;

    modport master (
        input  hold, code_data,
        output S, Phase, cycles, IR_q, PC_en, PC_add_rel, Jump_flag,
               Rn_ext, Ri_at, Addr_src, Addr_dst, illegal_op
    );

    modport slave (
        output hold, code_data,
        input  S, Phase, cycles, IR_q, PC_en, PC_add_rel, Jump_flag,
               Rn_ext, Ri_at, Addr_src, Addr_dst, illegal_op
    );
endinterface

// File: rtl/mcu_addr_seq.sv
// Clocked address sequencer: S1..S6 phase ring, instruction register and
// machine-cycle counter, decoded into PC controls and one-hot bus selects.
module mcu_addr_seq #(
    parameter int PHASE_CLKS = 1,
    parameter int SFR_NUM    = 7,
    parameter int CYC_W      = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    mcu_addr_seq_if.master bus
);
    localparam int SRC_W    = SFR_NUM + 6;
    localparam int DST_W    = SFR_NUM + 8;
    localparam int DIV_W    = (PHASE_CLKS > 1) ? $clog2(PHASE_CLKS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PHASE_CLKS - 1);

    localparam int SRC_CODE = SFR_NUM + 5;
    localparam int SRC_DATA = SFR_NUM + 4;
    localparam int DST_DATA = SFR_NUM + 7;
    localparam int DST_REL  = SFR_NUM + 5;
    localparam int DST_IR   = SFR_NUM + 4;
    localparam int SFR_A    = 1;

    typedef enum logic [2:0] {
        S4 = 3'b000, S1 = 3'b001, S3 = 3'b010,
        S2 = 3'b011, S5 = 3'b100, S6 = 3'b101
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP, OP_MOV_IMM, OP_MOV_A_RN, OP_MOV_RN_A,
        OP_MOV_A_RI, OP_MOV_RI_A, OP_SJMP, OP_ILLEGAL
    } op_t;

    typedef struct packed {
        logic             pc_en;
        logic             pc_rel;
        logic             jump;
        logic             illegal;
        logic             rn_ext;
        logic             ri_at;
        logic [SRC_W-1:0] src;
        logic [DST_W-1:0] dst;
    } dec_t;

    function automatic op_t classify(input logic [7:0] op);
        if (op == 8'h00)                return OP_NOP;
        else if (op == 8'h74)           return OP_MOV_IMM;
        else if (op == 8'h80)           return OP_SJMP;
        else if (op[7:3] == 5'b11101)   return OP_MOV_A_RN;
        else if (op[7:3] == 5'b11111)   return OP_MOV_RN_A;
        else if (op[7:1] == 7'b1110011) return OP_MOV_A_RI;
        else if (op[7:1] == 7'b1111011) return OP_MOV_RI_A;
        else                            return OP_ILLEGAL;
    endfunction

    // Value of the cycles counter during an instruction's first machine cycle.
    function automatic logic [CYC_W-1:0] first_cyc(input logic [7:0] op);
        return (op == 8'h80) ? CYC_W'(1) : '0;
    endfunction

    function automatic state_t next_state(input state_t s);
        case (s)
            S1:      return S2;
            S2:      return S3;
            S3:      return S4;
            S4:      return S5;
            S5:      return S6;
            default: return S1;
        endcase
    endfunction

    function automatic dec_t decode(input state_t s, input logic ph,
                                    input logic [CYC_W-1:0] cyc,
                                    input logic [7:0] ir);
        dec_t d;
        op_t  op;
        logic first;
        logic last;
        d     = '0;
        op    = classify(ir);
        last  = (cyc == '0);
        first = (cyc == first_cyc(ir));
        if (s == S6 && last) begin
            d.src[SRC_CODE] = 1'b1;
            d.dst[DST_IR]   = ph;
        end
        if (first) begin
            case (s)
                S1: begin
                    d.pc_en   = ph;
                    d.illegal = !ph && (op == OP_ILLEGAL);
                end
                S3: begin
                    d.rn_ext = (op == OP_MOV_A_RN) || (op == OP_MOV_RN_A);
                    d.ri_at  = (op == OP_MOV_A_RI) || (op == OP_MOV_RI_A);
                    if (ph) begin
                        case (op)
                            OP_MOV_IMM: begin
                                d.src[SRC_CODE] = 1'b1;
                                d.dst[SFR_A]    = 1'b1;
                            end
                            OP_MOV_A_RN, OP_MOV_A_RI: begin
                                d.src[SRC_DATA] = 1'b1;
                                d.dst[SFR_A]    = 1'b1;
                            end
                            OP_MOV_RN_A, OP_MOV_RI_A: begin
                                d.src[SFR_A]    = 1'b1;
                                d.dst[DST_DATA] = 1'b1;
                            end
                            OP_SJMP: begin
                                d.src[SRC_CODE] = 1'b1;
                                d.dst[DST_REL]  = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S5:      d.pc_en = !ph && (op == OP_MOV_IMM || op == OP_SJMP);
                default: ;
            endcase
        end
        if (op == OP_SJMP && last && s == S5 && !ph) begin
            d.pc_en  = 1'b1;
            d.pc_rel = 1'b1;
            d.jump   = 1'b1;
        end
        return d;
    endfunction

    state_t           s_q, s_n;
    logic             ph_q, ph_n;
    logic [CYC_W-1:0] cyc_q, cyc_n;
    logic [7:0]       ir_q, ir_n;
    logic [DIV_W-1:0] div_q;
    dec_t             dec_q;
    logic             tick;

    assign tick = (div_q == DIV_LAST) && !bus.hold;

    always_comb begin
        // NOTE: every target gets a default first, so no path can infer a latch.
        s_n   = s_q;
        ph_n  = ph_q;
        cyc_n = cyc_q;
        ir_n  = ir_q;
        if (tick) begin
            if (!ph_q) begin
                ph_n = 1'b1;
            end else begin
                ph_n = 1'b0;
                s_n  = next_state(s_q);
                if (s_q == S6) begin
                    if (cyc_q != '0) begin
                        cyc_n = cyc_q - 1'b1;
                    end else begin
                        ir_n  = bus.code_data;
                        cyc_n = first_cyc(bus.code_data);
                    end
                end
            end
        end
    end

    // Selects are decoded from the next state and registered on the tick, so
    // they read zero after reset until timing first moves.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!rst_n) begin
            s_q   <= S6;
            ph_q  <= 1'b0;
            cyc_q <= '0;
            ir_q  <= 8'h00;
            div_q <= '0;
            dec_q <= '0;
        end else begin
            if (!bus.hold) begin
                div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            end
            if (tick) begin
                s_q   <= s_n;
                ph_q  <= ph_n;
                cyc_q <= cyc_n;
                ir_q  <= ir_n;
                dec_q <= decode(s_n, ph_n, cyc_n, ir_n);
            end
        end
    end

    // Strobes gated by tick fire once per phase; hold simply defers them.
    assign bus.S          = s_q;
    assign bus.Phase      = ph_q;
    assign bus.cycles     = cyc_q;
    assign bus.IR_q       = ir_q;
    assign bus.PC_en      = dec_q.pc_en   & tick;
    assign bus.PC_add_rel = dec_q.pc_rel  & tick;
    assign bus.Jump_flag  = dec_q.jump    & tick;
    assign bus.illegal_op = dec_q.illegal & tick;
    assign bus.Rn_ext     = dec_q.rn_ext;
    assign bus.Ri_at      = dec_q.ri_at;
    assign bus.Addr_src   = dec_q.src;
    assign bus.Addr_dst   = tick ? dec_q.dst : '0;
endmodule

// File: tb/tb_mcu_addr_seq.sv
// Runs two sequencers (1 and 3 clocks per phase) against a phase-schedule
// reference model with directed opcode, hold and reset steps, then random stimulus.
module tb_mcu_addr_seq;
    localparam int SFR_NUM = 7;
    localparam int CYC_W   = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mcu_addr_seq_if #(.SFR_NUM(SFR_NUM), .CYC_W(CYC_W)) bus0 ();
    mcu_addr_seq_if #(.SFR_NUM(SFR_NUM), .CYC_W(CYC_W)) bus1 ();

    mcu_addr_seq #(.PHASE_CLKS(1), .SFR_NUM(SFR_NUM), .CYC_W(CYC_W)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.master)
    );
    mcu_addr_seq #(.PHASE_CLKS(3), .SFR_NUM(SFR_NUM), .CYC_W(CYC_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.master)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    // Model position: phase index 0..11 (S1P0..S6P1), clock within phase,
    // machine cycles left, opcode, and "no tick since reset".
    int         m_pidx[2];
    int         m_sub[2];
    int         m_rem[2];
    logic [7:0] m_ir[2];
    bit         m_fresh[2];
    int         pc_cnt[2], jmp_cnt[2], ill_cnt[2], dst_cnt[2];

    function automatic int pclk(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] observed(input int k);
        if (k == 0)
            return {bus0.S, bus0.Phase, bus0.cycles, bus0.IR_q, bus0.PC_en, bus0.PC_add_rel,
                    bus0.Jump_flag, bus0.Rn_ext, bus0.Ri_at, bus0.illegal_op,
                    bus0.Addr_src, bus0.Addr_dst};
        return {bus1.S, bus1.Phase, bus1.cycles, bus1.IR_q, bus1.PC_en, bus1.PC_add_rel,
                bus1.Jump_flag, bus1.Rn_ext, bus1.Ri_at, bus1.illegal_op,
                bus1.Addr_src, bus1.Addr_dst};
    endfunction

    // Expected outputs from the instruction timetable: src bits CODE=12 DATA=11 A=1,
    // dst bits DATA=14 rel=12 IR=11 A=1.
    function automatic logic [47:0] model_out(input int k, input logic h);
        logic        tick, pce, rel, jmp, rn, ri, ill;
        logic [12:0] src;
        logic [14:0] dst;
        logic [2:0]  s_enc;
        logic [7:0]  ir;
        logic [1:0]  rem2;
        int          st, ph, cno;
        pce = 0; rel = 0; jmp = 0; rn = 0; ri = 0; ill = 0;
        src = '0; dst = '0;
        ir   = m_ir[k];
        rem2 = m_rem[k][1:0];
        tick = (m_sub[k] == pclk(k) - 1) && !h;
        st   = m_pidx[k] / 2;
        ph   = m_pidx[k] % 2;
        case (st)
            0: s_enc = 3'b001;
            1: s_enc = 3'b011;
            2: s_enc = 3'b010;
            3: s_enc = 3'b000;
            4: s_enc = 3'b100;
            default: s_enc = 3'b101;
        endcase
        cno = ((ir == 8'h80) ? 2 : 1) - m_rem[k];
        if (!m_fresh[k]) begin
            if (m_rem[k] == 0 && st == 5) begin
                src[12] = 1;
                dst[11] = (ph == 1);
            end
            if (cno == 1 && m_pidx[k] == 1) pce = 1;
            if (m_pidx[k] == 0 && !(ir inside {8'h00, 8'h74, 8'h80, [8'hE6:8'hEF], [8'hF6:8'hFF]}))
                ill = 1;
            if (st == 2 && (ir inside {[8'hE8:8'hEF], [8'hF8:8'hFF]})) rn = 1;
            if (st == 2 && (ir inside {8'hE6, 8'hE7, 8'hF6, 8'hF7})) ri = 1;
            if (m_pidx[k] == 5) begin
                if (ir == 8'h74) begin src[12] = 1; dst[1] = 1; end
                else if (ir inside {[8'hE6:8'hEF]}) begin src[11] = 1; dst[1] = 1; end
                else if (ir inside {[8'hF6:8'hFF]}) begin src[1] = 1; dst[14] = 1; end
                else if (ir == 8'h80 && cno == 1) begin src[12] = 1; dst[12] = 1; end
            end
            if (m_pidx[k] == 8) begin
                if (ir == 8'h74) pce = 1;
                if (ir == 8'h80) begin
                    pce = 1;
                    if (cno == 2) begin rel = 1; jmp = 1; end
                end
            end
        end
        pce &= tick; rel &= tick; jmp &= tick; ill &= tick;
        if (!tick) dst = '0;
        return {s_enc, (ph == 1), rem2, ir, pce, rel, jmp, rn, ri, ill, src, dst};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pidx[k] = 10; m_sub[k] = 0; m_rem[k] = 0; m_ir[k] = 8'h00; m_fresh[k] = 1;
        end
    endtask

    task automatic model_advance(input logic h, input logic [7:0] cd, input logic r);
        bit t;
        if (!r) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (!h) begin
                t = (m_sub[k] == pclk(k) - 1);
                m_sub[k] = (m_sub[k] + 1) % pclk(k);
                if (t) begin
                    m_fresh[k] = 0;
                    if (m_pidx[k] == 11) begin
                        if (m_rem[k] == 0) begin
                            m_ir[k]  = cd;
                            m_rem[k] = (cd == 8'h80) ? 1 : 0;
                        end else begin
                            m_rem[k]--;
                        end
                    end
                    m_pidx[k] = (m_pidx[k] + 1) % 12;
                end
            end
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 2; k++) begin
            pc_cnt[k] = 0; jmp_cnt[k] = 0; ill_cnt[k] = 0; dst_cnt[k] = 0;
        end
    endtask

    // One clock: drive inputs, compare both instances, take the edge, advance model.
    task automatic step(input logic h, input logic [7:0] cd, input logic r);
        rst_n = r;
        bus0.hold = h; bus0.code_data = cd;
        bus1.hold = h; bus1.code_data = cd;
        #1;
        check("out_i0", observed(0), model_out(0, h));
        check("out_i1", observed(1), model_out(1, h));
        pc_cnt[0]  += int'(bus0.PC_en);      pc_cnt[1]  += int'(bus1.PC_en);
        jmp_cnt[0] += int'(bus0.Jump_flag);  jmp_cnt[1] += int'(bus1.Jump_flag);
        ill_cnt[0] += int'(bus0.illegal_op); ill_cnt[1] += int'(bus1.illegal_op);
        dst_cnt[0] += int'(bus0.Addr_dst[14]);
        @(posedge clk);
        #1;
        model_advance(h, cd, r);
    endtask

    task automatic run(input int n, input logic [7:0] cd);
        for (int i = 0; i < n; i++) step(1'b0, cd, 1'b1);
    endtask

    function automatic logic [7:0] pick_op();
        case ($urandom_range(0, 9))
            0: return 8'h00;
            1: return 8'h74;
            2: return 8'hE8 | 8'($urandom_range(0, 7));
            3: return 8'hF8 | 8'($urandom_range(0, 7));
            4: return 8'hE6 | 8'($urandom_range(0, 1));
            5: return 8'hF6 | 8'($urandom_range(0, 1));
            6: return 8'h80;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        bit found;
        rst_n = 1'b0;
        bus0.hold = 1'b0; bus0.code_data = 8'h00;
        bus1.hold = 1'b0; bus1.code_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        clear_counts();

        // NOP stream: reset state, first fetch, 12-clock machine cycles.
        run(40, 8'h00);

        // MOV A,#d: two PC_en per machine cycle, each one clock wide.
        run(40, 8'h74);
        clear_counts();
        run(36, 8'h74);
        check("pc_en_74_i0", pc_cnt[0], 6);
        check("pc_en_74_i1", pc_cnt[1], 2);

        // SJMP: three PC_en and one jump per two-cycle instruction.
        run(40, 8'h80);
        clear_counts();
        run(72, 8'h80);
        check("pc_en_sjmp_i0", pc_cnt[0], 9);
        check("jump_sjmp_i0", jmp_cnt[0], 3);
        check("pc_en_sjmp_i1", pc_cnt[1], 3);
        check("jump_sjmp_i1", jmp_cnt[1], 1);

        // Unsupported opcode: one illegal_op pulse per instruction.
        run(40, 8'hA5);
        clear_counts();
        run(36, 8'hA5);
        check("illegal_i0", ill_cnt[0], 3);
        check("illegal_i1", ill_cnt[1], 1);

        // MOV R3,A with hold raised for 5 clocks at S3P1 of the fast instance.
        run(40, 8'hFB);
        found = 0;
        for (int i = 0; i < 24 && !found; i++) begin
            if (m_pidx[0] == 5) found = 1;
            else step(1'b0, 8'hFB, 1'b1);
        end
        check("hold_align", found, 1);
        clear_counts();
        repeat (5) step(1'b1, 8'hFB, 1'b1);
        check("hold_no_dst", dst_cnt[0], 0);
        step(1'b0, 8'hFB, 1'b1);
        check("hold_dst_once", dst_cnt[0], 1);
        run(30, 8'hFB);

        // Reset at S4 of SJMP cycle 1.
        run(40, 8'h80);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (m_pidx[0] == 6 && m_rem[0] == 1) found = 1;
            else step(1'b0, 8'h80, 1'b1);
        end
        check("rst_align", found, 1);
        step(1'b0, 8'h80, 1'b0);
        rst_n = 1'b1;
        #1;
        check("rst_mid_i0", observed(0), {3'b101, 45'd0});
        check("rst_mid_i1", observed(1), {3'b101, 45'd0});
        run(30, 8'h80);

        // Random opcodes, hold and occasional resets.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 7) == 0), pick_op(), ($urandom_range(0, 199) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
